// File: rtl/memory_fill_responder_pkg.sv
// memory_fill_responder_pkg
// Shared widths, default read latency and the pipeline stage record used by
// memory_fill_responder and its read pipeline stages.
package memory_fill_responder_pkg;

  localparam int WORD_W          = 16;
  localparam int ADDR_W          = 16;
  localparam int LATENCY_DEFAULT = 4;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/memory_fill_responder_read_pipe_stage.sv
// mem_read_pipe_stage
// One {valid, data} register of the read-return pipeline. Reset clears both
// the valid bit and the data so no stale word can leak out after reset.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   d     - stage input record
//   q     - registered stage record
module mem_read_pipe_stage
  import memory_fill_responder_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_fill_responder.sv
// memory_fill_responder
// Word-addressed 16-bit memory model with a fixed-latency, fully pipelined
// read return path. Writes land on the accepting edge; reads sample the array
// on the accepting edge and return LATENCY cycles later, in issue order.
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   enable     - request strobe, one request per edge while high
//   wr         - 1 = write, 0 = read (qualified by enable)
//   addr       - byte address; word index is addr[ADDR_WIDTH:1]
//   data_in    - write data
//   data_out   - read data, 0 when data_valid is low
//   data_valid - one-cycle pulse per returned read
//   pending    - reads accepted but not yet returned
//   busy       - pending != 0
module memory_fill_responder
  import memory_fill_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = LATENCY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic [2:0]        pending,
  output logic              busy
);

  logic [WORD_W-1:0]     mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  rd_accept;
  logic                  unused_addr_bits;
  stage_t                stage_in;
  stage_t                stage_q [LATENCY];

  // Byte-lane bit and high bits alias silently onto the same word.
  assign word_idx         = addr[ADDR_WIDTH:1];
  assign unused_addr_bits = ^{addr[0], addr[ADDR_W-1:ADDR_WIDTH+1]};
  assign rd_accept        = enable & ~wr;

  // Array is intentionally not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (enable && wr) begin
      mem[word_idx] <= data_in;
    end
  end

  // Stage 0 captures the pre-edge array contents, so a write on the same
  // edge as a read is not visible to that read, but is to the next one.
  always_comb begin
    stage_in = '0;
    if (rd_accept) begin
      stage_in.valid = 1'b1;
      stage_in.data  = mem[word_idx];
    end
  end

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    if (i == 0) begin : g_first
      mem_read_pipe_stage u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (stage_in),
        .q     (stage_q[0])
      );
    end else begin : g_next
      mem_read_pipe_stage u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (stage_q[i-1]),
        .q     (stage_q[i])
      );
    end
  end

  assign data_valid = stage_q[LATENCY-1].valid;
  assign data_out   = data_valid ? stage_q[LATENCY-1].data : '0;

  // Accept and return on the same edge cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 3'd0;
    end else begin
      case ({rd_accept, data_valid})
        2'b10:   pending <= pending + 3'd1;
        2'b01:   pending <= pending - 3'd1;
        default: pending <= pending;
      endcase
    end
  end

  assign busy = (pending != 3'd0);

endmodule
